// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, ALU op codes, branch codes and a branch
//                condition helper for the 16-bit pipelined processor.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int REG_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Branch type select
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQZ = 2'b01;
    localparam logic [1:0] BR_BNEZ = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    // Branch condition evaluated on operand A only.
    function automatic logic branch_cond(input logic [1:0] br, input data_t a);
        logic r;
        case (br)
            BR_BEQZ: r = (a == '0);
            BR_BNEZ: r = (a != '0);
            BR_JMP:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_if.sv
`default_nettype none
// ============================================================================
//  Module      : execute_if
//  Description : Decode-to-execute operand/control bundle and the execute
//                stage's write-back / branch results.
//                master : decode side (drives operands, receives results)
//                slave  : execute stage
//  Revision    : 1.0  initial release
// ============================================================================
interface execute_if;
    import cpu_pkg::*;

    // decode -> execute
    data_t      do1;
    data_t      do2;
    data_t      imm;
    addr_t      disp8;
    addr_t      nxtadrsrr;
    reg_idx_t   dest;
    logic [1:0] alucnt;
    logic       sel;
    logic       wes;
    logic [1:0] branchs;

    // execute -> decode / fetch
    data_t      wdata_w;
    reg_idx_t   dest_w;
    logic       we_w;
    logic       bj;
    addr_t      tgt;
    logic       zf;
    logic [15:0] retired;

    modport master (
        output do1, do2, imm, disp8, nxtadrsrr, dest, alucnt, sel, wes, branchs,
        input  wdata_w, dest_w, we_w, bj, tgt, zf, retired
    );

    modport slave (
        input  do1, do2, imm, disp8, nxtadrsrr, dest, alucnt, sel, wes, branchs,
        output wdata_w, dest_w, we_w, bj, tgt, zf, retired
    );

endinterface
`default_nettype wire

// File: rtl/alu_16.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16
//  Description : Combinational 16-bit ALU, wrapping arithmetic, no carry out.
//  Ports       : a, b (operands), op (ALU_* code) -> y (result)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_16
    import cpu_pkg::*;
(
    input  data_t      a,
    input  data_t      b,
    input  logic [1:0] op,
    output data_t      y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute.sv
`default_nettype none
// ============================================================================
//  Module      : execute
//  Description : Execute stage. Computes the ALU result, registers the
//                write-back triple, resolves branches and holds bj high for
//                FLUSH_CYCLES cycles after a taken branch, during which the
//                incoming instructions are treated as bubbles.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-low reset
//                ex   - execute_if.slave (operands in, results out)
//  Revision    : 1.0  initial release
// ============================================================================
module execute
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2   // legal range 1..3
) (
    input  wire logic clk,
    input  wire logic rst,
    execute_if.slave  ex
);

    data_t       w_opb;
    data_t       w_alu;
    logic        w_valid;
    logic        w_taken;

    data_t       r_wdata;
    reg_idx_t    r_dest;
    logic        r_we;
    addr_t       r_tgt;
    logic        r_zf;
    logic [15:0] r_retired;
    logic [1:0]  r_flush_cnt;

    assign w_opb = ex.sel ? ex.imm : ex.do2;

    alu_16 u_alu (
        .a  (ex.do1),
        .b  (w_opb),
        .op (ex.alucnt),
        .y  (w_alu)
    );

    // While flushing, wes/branchs are ignored here regardless of whether
    // decode has already squashed them.
    assign w_valid = (r_flush_cnt == 2'd0);
    assign w_taken = w_valid && branch_cond(ex.branchs, ex.do1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdata     <= '0;
            r_dest      <= '0;
            r_we        <= 1'b0;
            r_tgt       <= '0;
            r_zf        <= 1'b0;
            r_retired   <= '0;
            r_flush_cnt <= 2'd0;
        end else begin
            r_wdata <= w_alu;
            r_dest  <= ex.dest;
            r_we    <= ex.wes & w_valid;

            if (ex.wes && w_valid) begin
                r_zf <= (w_alu == '0);
            end

            if (w_valid) begin
                r_retired <= r_retired + 16'd1;
            end

            if (w_taken) begin
                r_flush_cnt <= 2'(FLUSH_CYCLES);
                r_tgt       <= ex.nxtadrsrr + ex.disp8;
            end else if (!w_valid) begin
                r_flush_cnt <= r_flush_cnt - 2'd1;
            end
        end
    end

    assign ex.wdata_w = r_wdata;
    assign ex.dest_w  = r_dest;
    assign ex.we_w    = r_we;
    assign ex.tgt     = r_tgt;
    assign ex.zf      = r_zf;
    assign ex.retired = r_retired;
    // bj decodes straight from the counter register: no input-to-bj path.
    assign ex.bj      = (r_flush_cnt != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute
//  Description : Self-checking bench for the execute stage with a
//                cycle-level behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_execute;

    localparam int FC = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    execute_if bus ();

    execute #(.FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state (values expected after the most recent edge)
    logic [15:0] m_wdata;
    logic [3:0]  m_dest;
    logic        m_we;
    logic        m_zf;
    logic [7:0]  m_tgt;
    logic [15:0] m_retired;
    int          m_shadow;   // remaining bubble cycles after a taken branch

    task automatic model_edge();
        logic [15:0] b;
        logic [15:0] r;
        bit          valid;
        bit          taken;
        if (rst == 1'b0) begin
            m_wdata = 0; m_dest = 0; m_we = 0; m_zf = 0;
            m_tgt = 0; m_retired = 0; m_shadow = 0;
            return;
        end
        valid = (m_shadow == 0);
        b = bus.sel ? bus.imm : bus.do2;
        case (bus.alucnt)
            2'd0:    r = bus.do1 + b;
            2'd1:    r = bus.do1 - b;
            2'd2:    r = bus.do1 & b;
            default: r = bus.do1 | b;
        endcase
        taken = valid && ((bus.branchs == 2'd1 && bus.do1 == 0) ||
                          (bus.branchs == 2'd2 && bus.do1 != 0) ||
                          (bus.branchs == 2'd3));
        m_wdata = r;
        m_dest  = bus.dest;
        m_we    = bus.wes && valid;
        if (m_we) m_zf = (r == 0);
        if (valid) m_retired = m_retired + 16'd1;
        if (taken) begin
            m_shadow = FC;
            m_tgt    = bus.nxtadrsrr + bus.disp8;
        end else if (m_shadow > 0) begin
            m_shadow = m_shadow - 1;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] im,
                         input logic s, input logic [1:0] op, input logic [3:0] d,
                         input logic w, input logic [1:0] br,
                         input logic [7:0] nxt, input logic [7:0] disp);
        bus.do1 = a; bus.do2 = b; bus.imm = im; bus.sel = s; bus.alucnt = op;
        bus.dest = d; bus.wes = w; bus.branchs = br; bus.nxtadrsrr = nxt; bus.disp8 = disp;
    endtask

    task automatic drive_random(input bit allow_branch);
        drive(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
              4'($urandom), 1'($urandom),
              allow_branch ? 2'($urandom) : 2'd0, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_random(1'b1);
        cycle();
        drive_random(1'b1);
        cycle();
        n_checks++; if (bus.wdata_w !== 16'h0) begin n_errors++; $display("FAIL reset_wdata: got %h expected 0000", bus.wdata_w); end
        n_checks++; if (bus.dest_w !== 4'h0) begin n_errors++; $display("FAIL reset_dest: got %h expected 0", bus.dest_w); end
        n_checks++; if (bus.we_w !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b expected 0", bus.we_w); end
        n_checks++; if (bus.bj !== 1'b0) begin n_errors++; $display("FAIL reset_bj: got %b expected 0", bus.bj); end
        n_checks++; if (bus.tgt !== 8'h0) begin n_errors++; $display("FAIL reset_tgt: got %h expected 00", bus.tgt); end
        n_checks++; if (bus.zf !== 1'b0) begin n_errors++; $display("FAIL reset_zf: got %b expected 0", bus.zf); end
        n_checks++; if (bus.retired !== 16'h0) begin n_errors++; $display("FAIL reset_retired: got %h expected 0000", bus.retired); end
    endtask

    task automatic test_alu();
        rst = 1'b1;
        // ADD register form
        drive(16'h0003, 16'h0004, 16'h1234, 1'b0, 2'b00, 4'd5, 1'b1, 2'b00, 8'h00, 8'h00);
        cycle();
        n_checks++; if (bus.wdata_w !== 16'h0007) begin n_errors++; $display("FAIL add_wdata: got %h expected 0007", bus.wdata_w); end
        n_checks++; if (bus.dest_w !== 4'd5) begin n_errors++; $display("FAIL add_dest: got %0d expected 5", bus.dest_w); end
        n_checks++; if (bus.we_w !== 1'b1) begin n_errors++; $display("FAIL add_we: got %b expected 1", bus.we_w); end
        n_checks++; if (bus.zf !== 1'b0) begin n_errors++; $display("FAIL add_zf: got %b expected 0", bus.zf); end
        n_checks++; if (bus.retired !== 16'd1) begin n_errors++; $display("FAIL add_retired: got %0d expected 1", bus.retired); end
        // SUB immediate with wrap
        drive(16'h0000, 16'h5555, 16'h0001, 1'b1, 2'b01, 4'd2, 1'b1, 2'b00, 8'h00, 8'h00);
        cycle();
        n_checks++; if (bus.wdata_w !== 16'hFFFF) begin n_errors++; $display("FAIL subi_wdata: got %h expected ffff", bus.wdata_w); end
        // AND to zero sets zf
        drive(16'h00F0, 16'h000F, 16'h0000, 1'b0, 2'b10, 4'd3, 1'b1, 2'b00, 8'h00, 8'h00);
        cycle();
        n_checks++; if (bus.wdata_w !== 16'h0000) begin n_errors++; $display("FAIL and_wdata: got %h expected 0000", bus.wdata_w); end
        n_checks++; if (bus.zf !== 1'b1) begin n_errors++; $display("FAIL and_zf: got %b expected 1", bus.zf); end
        // OR without write enable: zf must hold
        drive(16'h0F00, 16'h00F0, 16'h0000, 1'b0, 2'b11, 4'd4, 1'b0, 2'b00, 8'h00, 8'h00);
        cycle();
        n_checks++; if (bus.wdata_w !== 16'h0FF0) begin n_errors++; $display("FAIL or_wdata: got %h expected 0ff0", bus.wdata_w); end
        n_checks++; if (bus.we_w !== 1'b0 || bus.zf !== 1'b1) begin n_errors++; $display("FAIL or_we_zf: got we=%b zf=%b expected we=0 zf=1", bus.we_w, bus.zf); end
        n_checks++; if (bus.retired !== 16'd4) begin n_errors++; $display("FAIL or_retired: got %0d expected 4", bus.retired); end
    endtask

    task automatic test_branch_flush();
        logic [15:0] ret0;
        ret0 = bus.retired;
        drive(16'h0000, 16'h0001, 16'h0000, 1'b0, 2'b00, 4'd1, 1'b0, 2'b01, 8'hF0, 8'h20);
        cycle();
        n_checks++; if (bus.bj !== 1'b1) begin n_errors++; $display("FAIL beqz_bj: got %b expected 1", bus.bj); end
        n_checks++; if (bus.tgt !== 8'h10) begin n_errors++; $display("FAIL beqz_tgt: got %h expected 10", bus.tgt); end
        n_checks++; if (bus.retired !== ret0 + 16'd1) begin n_errors++; $display("FAIL beqz_retired: got %0d expected %0d", bus.retired, ret0 + 16'd1); end
        // shadow: writes and a JMP must be ignored
        for (int i = 1; i <= FC; i++) begin
            drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 4'd7, 1'b1, 2'b11, 8'h40, 8'h01);
            cycle();
            n_checks++; if (bus.we_w !== 1'b0) begin n_errors++; $display("FAIL shadow_we[%0d]: got %b expected 0", i, bus.we_w); end
            n_checks++; if (bus.bj !== (i < FC)) begin n_errors++; $display("FAIL shadow_bj[%0d]: got %b expected %b", i, bus.bj, (i < FC)); end
            n_checks++; if (bus.tgt !== 8'h10) begin n_errors++; $display("FAIL shadow_tgt[%0d]: got %h expected 10", i, bus.tgt); end
            n_checks++; if (bus.retired !== ret0 + 16'd1) begin n_errors++; $display("FAIL shadow_retired[%0d]: got %0d expected %0d", i, bus.retired, ret0 + 16'd1); end
        end
    endtask

    task automatic test_bnez_not_taken();
        logic [15:0] ret0;
        ret0 = bus.retired;
        drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 4'd0, 1'b0, 2'b10, 8'h77, 8'h11);
        cycle();
        n_checks++; if (bus.bj !== 1'b0) begin n_errors++; $display("FAIL bnez_bj: got %b expected 0", bus.bj); end
        n_checks++; if (bus.tgt !== 8'h10) begin n_errors++; $display("FAIL bnez_tgt: got %h expected 10", bus.tgt); end
        n_checks++; if (bus.retired !== ret0 + 16'd1) begin n_errors++; $display("FAIL bnez_retired: got %0d expected %0d", bus.retired, ret0 + 16'd1); end
    endtask

    task automatic test_reset_mid_flush();
        drive(16'h1234, 16'h0000, 16'h0000, 1'b0, 2'b00, 4'd9, 1'b1, 2'b11, 8'h12, 8'h03);
        cycle();
        n_checks++; if (bus.bj !== 1'b1 || bus.tgt !== 8'h15) begin n_errors++; $display("FAIL jmp_taken: got bj=%b tgt=%h expected bj=1 tgt=15", bus.bj, bus.tgt); end
        rst = 1'b0;
        drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00);
        cycle();
        n_checks++; if (bus.bj !== 1'b0 || bus.tgt !== 8'h00 || bus.retired !== 16'h0 || bus.wdata_w !== 16'h0 || bus.we_w !== 1'b0 || bus.zf !== 1'b0 || bus.dest_w !== 4'h0)
            begin n_errors++; $display("FAIL midflush_reset: got bj=%b tgt=%h ret=%h wd=%h we=%b zf=%b dest=%h expected all zero",
                                       bus.bj, bus.tgt, bus.retired, bus.wdata_w, bus.we_w, bus.zf, bus.dest_w); end
        rst = 1'b1;
        drive(16'h0001, 16'h0002, 16'h0000, 1'b0, 2'b00, 4'd3, 1'b1, 2'b00, 8'h00, 8'h00);
        cycle();
        n_checks++; if (bus.wdata_w !== 16'h0003 || bus.we_w !== 1'b1 || bus.dest_w !== 4'd3 || bus.retired !== 16'd1 || bus.bj !== 1'b0)
            begin n_errors++; $display("FAIL post_reset_add: got wd=%h we=%b dest=%0d ret=%0d bj=%b expected wd=0003 we=1 dest=3 ret=1 bj=0",
                                       bus.wdata_w, bus.we_w, bus.dest_w, bus.retired, bus.bj); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            drive_random(1'b1);
            cycle();
            n_checks++;
            if (bus.wdata_w !== m_wdata || bus.dest_w !== m_dest || bus.we_w !== m_we ||
                bus.zf !== m_zf || bus.tgt !== m_tgt || bus.retired !== m_retired ||
                bus.bj !== (m_shadow != 0)) begin
                n_errors++;
                $display("FAIL random[%0d]: got wd=%h dest=%h we=%b zf=%b tgt=%h ret=%h bj=%b expected wd=%h dest=%h we=%b zf=%b tgt=%h ret=%h bj=%b",
                         i, bus.wdata_w, bus.dest_w, bus.we_w, bus.zf, bus.tgt, bus.retired, bus.bj,
                         m_wdata, m_dest, m_we, m_zf, m_tgt, m_retired, (m_shadow != 0));
            end
        end
    endtask

    task automatic test_retired_wrap();
        rst = 1'b0;
        drive_random(1'b0);
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive_random(1'b0);
            cycle();
        end
        n_checks++; if (bus.retired !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_preload: got %h expected ffff", bus.retired); end
        drive_random(1'b0);
        cycle();
        n_checks++; if (bus.retired !== 16'h0000) begin n_errors++; $display("FAIL wrap_zero: got %h expected 0000", bus.retired); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive(16'h0, 16'h0, 16'h0, 1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 8'h0, 8'h0);
        m_wdata = 0; m_dest = 0; m_we = 0; m_zf = 0; m_tgt = 0; m_retired = 0; m_shadow = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_branch_flush();
        test_bnez_not_taken();
        test_reset_mid_flush();
        test_random();
        test_retired_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
